sseg_mux_driver: RTL and testbench

Time-multiplexed driver for a row of N common-anode/common-cathode seven-segment digits, the successor to the single-digit hex decoder. It captures a packed hex word and a decimal-point vector into a shadow register and scans the digits one at a time at a programmable refresh rate. Each slot includes an anti-ghosting blanking interval, and leading zeros can optionally be suppressed. It sits between the datapath that produces display values and the board's segment and digit-enable pins.

---
 rtl/sseg_mux_driver_pkg.sv | 14 +
 rtl/sseg_mux_driver_decode.sv | 15 +
 rtl/sseg_mux_driver.sv | 120 ++++++++++++
 tb/tb_sseg_mux_driver.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_mux_driver_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyph table and blank pattern.
package sseg_pkg;

  localparam logic [6:0] SSEG_BLANK = 7'h00;

  // Segment patterns g..a for hex digits 0..F
  localparam logic [6:0] SSEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/sseg_mux_driver_decode.sv
// Combinational hex-to-segment decoder with a suppress input for leading-zero blanking.
module sseg_decode
  import sseg_pkg::*;
(
  input  logic [3:0] i_nibble,
  input  logic       i_suppress,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SSEG_HEX[i_nibble];
    if (i_suppress) o_seg = SSEG_BLANK;
  end

endmodule

// File: rtl/sseg_mux_driver.sv
// Time-multiplexed N-digit seven-segment driver: shadowed display word, per-slot
// blanking against ghosting, optional leading-zero suppression, registered pin outputs.
module sseg_mux_driver
  import sseg_pkg::*;
#(
  parameter int unsigned N_DIGITS      = 4,
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter int unsigned BLANK_CYCLES  = 16,
  parameter int unsigned AN_ACTIVE_LOW = 1,
  localparam int unsigned IW           = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  load,
  input  logic [4*N_DIGITS-1:0] hex_in,
  input  logic [N_DIGITS-1:0]   dp_in,
  input  logic                  blank_lz,
  output logic [7:0]            sseg,
  output logic [N_DIGITS-1:0]   an,
  output logic [IW-1:0]         digit_idx,
  output logic                  frame_done
);

  localparam int unsigned CW = $clog2(REFRESH_DIV);
  localparam logic [N_DIGITS-1:0] AN_OFF = (AN_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

  logic [CW-1:0]         r_cnt;
  logic [IW-1:0]         r_idx;
  logic [4*N_DIGITS-1:0] r_hex;
  logic [N_DIGITS-1:0]   r_dp;
  logic                  r_blz;

  logic                  w_slot_end;
  logic                  w_idx_last;
  logic                  w_active;
  logic [N_DIGITS-1:0]   w_lz;
  logic                  w_run;
  logic [3:0]            w_nib;
  logic                  w_dp;
  logic                  w_sup;
  logic [6:0]            w_seg;
  logic [N_DIGITS-1:0]   w_onehot;

  assign w_slot_end = (r_cnt == CW'(REFRESH_DIV - 1));
  assign w_idx_last = (r_idx == IW'(N_DIGITS - 1));
  assign w_active   = en && (r_cnt >= CW'(BLANK_CYCLES));
  assign w_onehot   = N_DIGITS'(1) << r_idx;

  // Suppression mask: a digit is blank when it and every digit above it is zero
  always_comb begin
    w_lz  = '0;
    w_run = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      w_run   = w_run & (r_hex[4*i +: 4] == 4'h0);
      w_lz[i] = w_run & r_blz;
    end
  end

  always_comb begin
    w_nib = '0;
    w_dp  = 1'b0;
    w_sup = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_idx == IW'(i)) begin
        w_nib = r_hex[4*i +: 4];
        w_dp  = r_dp[i];
        w_sup = w_lz[i];
      end
    end
  end

  sseg_decode u_decode (
    .i_nibble   (w_nib),
    .i_suppress (w_sup),
    .o_seg      (w_seg)
  );

  // Prescaler and digit index; both freeze while scanning is disabled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (en) begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= w_idx_last ? '0 : r_idx + IW'(1);
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hex <= '0;
      r_dp  <= '0;
      r_blz <= 1'b0;
    end else if (load) begin
      r_hex <= hex_in;
      r_dp  <= dp_in;
      r_blz <= blank_lz;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sseg       <= 8'h00;
      an         <= AN_OFF;
      digit_idx  <= '0;
      frame_done <= 1'b0;
    end else begin
      sseg       <= w_active ? {w_dp, w_seg} : 8'h00;
      an         <= w_active ? (w_onehot ^ AN_OFF) : AN_OFF;
      digit_idx  <= r_idx;
      frame_done <= en & w_slot_end & w_idx_last;
    end
  end

endmodule

// File: tb/tb_sseg_mux_driver.sv
// Directed bench for sseg_mux_driver: a cycle model pushes expected outputs to a queue,
// which are popped and checked after each clock edge, plus spot checks against fixed patterns.
module tb_sseg_mux_driver;

  localparam int unsigned N   = 4;
  localparam int unsigned DIV = 8;
  localparam int unsigned BLK = 2;

  typedef struct packed {
    logic [7:0] sseg;
    logic [3:0] an;
    logic [1:0] idx;
    logic       fd;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        load;
  logic [15:0] hex_in;
  logic [3:0]  dp_in;
  logic        blank_lz;
  logic [7:0]  sseg;
  logic [3:0]  an;
  logic [1:0]  digit_idx;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t        sb_q[$];
  int          m_cnt;
  int          m_idx;
  logic [15:0] m_hex;
  logic [3:0]  m_dp;
  logic        m_blz;
  logic [7:0]  last_seg [4];
  int          cyc;
  int          prev_fd;
  bit          check_period;

  sseg_mux_driver #(
    .N_DIGITS      (N),
    .REFRESH_DIV   (DIV),
    .BLANK_CYCLES  (BLK),
    .AN_ACTIVE_LOW (1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .load       (load),
    .hex_in     (hex_in),
    .dp_in      (dp_in),
    .blank_lz   (blank_lz),
    .sseg       (sseg),
    .an         (an),
    .digit_idx  (digit_idx),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] dec7(input logic [3:0] v);
    case (v)
      4'h0: return 7'b0111111;  4'h1: return 7'b0000110;
      4'h2: return 7'b1011011;  4'h3: return 7'b1001111;
      4'h4: return 7'b1100110;  4'h5: return 7'b1101101;
      4'h6: return 7'b1111101;  4'h7: return 7'b0000111;
      4'h8: return 7'b1111111;  4'h9: return 7'b1101111;
      4'hA: return 7'b1110111;  4'hB: return 7'b1111100;
      4'hC: return 7'b0111001;  4'hD: return 7'b1011110;
      4'hE: return 7'b1111001;  default: return 7'b1110001;
    endcase
  endfunction

  // Highest non-zero digit bounds what is shown; digits above it are blanked
  function automatic logic [6:0] model_seg(input int i);
    int top;
    top = 0;
    for (int k = 0; k < 4; k++) if (m_hex[4*k +: 4] != 4'h0) top = k;
    if (m_blz && i > top) return 7'h00;
    return dec7(m_hex[4*i +: 4]);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_idx = 0; m_hex = '0; m_dp = '0; m_blz = 1'b0;
  endtask

  task automatic step();
    exp_t e;
    exp_t g;
    bit   act;
    act    = en && (m_cnt >= int'(BLK));
    e.sseg = act ? {m_dp[m_idx], model_seg(m_idx)} : 8'h00;
    e.an   = act ? ~(4'b0001 << m_idx) : 4'b1111;
    e.idx  = 2'(m_idx);
    e.fd   = en && (m_cnt == int'(DIV) - 1) && (m_idx == int'(N) - 1);
    sb_q.push_back(e);
    if (load) begin m_hex = hex_in; m_dp = dp_in; m_blz = blank_lz; end
    if (en) begin
      if (m_cnt == int'(DIV) - 1) begin m_cnt = 0; m_idx = (m_idx + 1) % int'(N); end
      else m_cnt++;
    end
    @(posedge clk);
    #1;
    cyc++;
    g = sb_q.pop_front();
    chk("sseg", 32'(sseg), 32'(g.sseg));
    chk("an", 32'(an), 32'(g.an));
    chk("digit_idx", 32'(digit_idx), 32'(g.idx));
    chk("frame_done", 32'(frame_done), 32'(g.fd));
    if (an !== 4'b1111) last_seg[digit_idx] = sseg;
    if (frame_done === 1'b1) begin
      if (check_period && prev_fd >= 0) chk("frame_period", 32'(cyc - prev_fd), 32'd32);
      prev_fd = cyc;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until(input int cnt, input int idx);
    int k;
    k = 0;
    while (!(m_cnt == cnt && (idx < 0 || m_idx == idx)) && k < 100) begin
      step();
      k++;
    end
    chk("run_until_bound", 32'(k < 100), 32'd1);
  endtask

  task automatic do_load(input logic [15:0] h, input logic [3:0] d, input logic b);
    load = 1'b1; hex_in = h; dp_in = d; blank_lz = b;
    step();
    load = 1'b0;
  endtask

  task automatic clear_last();
    for (int i = 0; i < 4; i++) last_seg[i] = 8'hEE;
  endtask

  initial begin
    cyc = 0; prev_fd = -1; check_period = 1'b0;
    rst = 1'b1; en = 1'b0; load = 1'b0; hex_in = '0; dp_in = '0; blank_lz = 1'b0;
    model_reset();
    #12;
    chk("rst_sseg", 32'(sseg), 32'h00);
    chk("rst_an", 32'(an), 32'hF);
    chk("rst_idx", 32'(digit_idx), 32'd0);
    chk("rst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0;

    // Basic scan of 1234
    do_load(16'h1234, 4'b0000, 1'b0);
    en = 1'b1;
    check_period = 1'b1; prev_fd = -1;
    run(2);
    chk("first_blank_an", 32'(an), 32'hF);
    run(1);
    chk("first_digit0_an", 32'(an), 32'b1110);
    chk("first_digit0_seg", 32'(sseg), 32'h66);
    run(29 + 64);

    // Leading-zero blanking with a decimal point on a suppressed digit
    clear_last();
    do_load(16'h00A0, 4'b0100, 1'b1);
    run(64);
    chk("lz_d3", 32'(last_seg[3]), 32'h00);
    chk("lz_d2", 32'(last_seg[2]), 32'h80);
    chk("lz_d1", 32'(last_seg[1]), 32'h77);
    chk("lz_d0", 32'(last_seg[0]), 32'h3F);

    clear_last();
    do_load(16'h0000, 4'b0000, 1'b1);
    run(64);
    chk("zero_d3", 32'(last_seg[3]), 32'h00);
    chk("zero_d2", 32'(last_seg[2]), 32'h00);
    chk("zero_d1", 32'(last_seg[1]), 32'h00);
    chk("zero_d0", 32'(last_seg[0]), 32'h3F);

    // Every glyph on digit 0
    for (int v = 0; v < 16; v++) begin
      logic [3:0] nv;
      nv = 4'(v);
      clear_last();
      do_load({12'h000, nv}, 4'b0000, 1'b0);
      run(32);
      chk("glyph", 32'(last_seg[0][6:0]), 32'(dec7(nv)));
    end
    chk("glyph_F", 32'(last_seg[0][6:0]), 32'h71);
    check_period = 1'b0;

    // Enable dropped mid-slot
    do_load(16'h9876, 4'b1010, 1'b0);
    run_until(4, 1);
    en = 1'b0;
    run(5);
    chk("pause_an", 32'(an), 32'hF);
    chk("pause_idx", 32'(digit_idx), 32'd1);
    en = 1'b1;
    run(40);

    // Asynchronous reset between edges
    run_until(5, 2);
    chk("pre_rst_active", 32'(an), 32'b1011);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_sseg", 32'(sseg), 32'h00);
    chk("arst_an", 32'(an), 32'hF);
    chk("arst_idx", 32'(digit_idx), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();

    // Load coinciding with a slot advance shows with the next digit
    run_until(int'(DIV) - 1, 0);
    load = 1'b1; hex_in = 16'h5678; dp_in = 4'b0000; blank_lz = 1'b0;
    step();
    load = 1'b0;
    run(3);
    chk("adv_load_an", 32'(an), 32'b1101);
    chk("adv_load_seg", 32'(sseg), 32'h07);
    run(32);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
